// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO request arbiter: LIFO geometry, operation
// codes, FSM state encoding and the push/pop fault rule.
package lifo_pkg;

  localparam int LIFO_DW    = 6;
  localparam int LIFO_DEPTH = 4;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  // A push into a full LIFO or a pop from an empty one must not touch the LIFO.
  function automatic logic op_fault(input logic op_i, input logic full_i, input logic empty_i);
    return (op_i == OP_PUSH) ? full_i : empty_i;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: searches upward from ptr_i, wrapping,
// and returns the first requester found as one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW-1:0] cand_s;

  // Walk the requesters in priority order starting at the pointer; first hit wins.
  always_comb begin
    win_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand_s]) begin
        any_o         = 1'b1;
        idx_o         = cand_s;
        win_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/lifo_req_arbiter.sv
// Arbitrates push/pop requests from several requesters onto one shared LIFO.
// Each operation runs IDLE -> ISSUE -> WAIT -> DONE, giving one access per
// four cycles; flags are only sampled in IDLE since this block is the sole
// LIFO driver.
module lifo_req_arbiter
  import lifo_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = LIFO_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    op,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic                  lifo_write,
  output logic                  lifo_read,
  output logic [DW-1:0]         lifo_din,
  input  logic [DW-1:0]         lifo_dout,
  input  logic                  lifo_empty,
  input  logic                  lifo_full
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          op_q, op_d;
  logic          fault_q, fault_d;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [DW-1:0]      din_q, din_d;

  logic [NUM_REQ-1:0] pick_win_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic               pick_op_s;
  logic               pick_fault_s;
  logic [DW-1:0]      pick_data_s;
  logic [DW-1:0]      wd_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wd
    assign wd_arr_s[g] = wdata[g*DW +: DW];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .win_o (pick_win_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign pick_op_s    = op[pick_idx_s];
  assign pick_data_s  = wd_arr_s[pick_idx_s];
  assign pick_fault_s = op_fault(pick_op_s, lifo_full, lifo_empty);

  // State, latched request context and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      op_q    <= 1'b0;
      fault_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      fault_q <= fault_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      din_q   <= din_d;
    end
  end

  // Next state; the winner's context and the rotated pointer are captured on leaving IDLE.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = ISSUE;
          rr_d    = IW'((int'(pick_idx_s) + 1) % NUM_REQ);
          idx_d   = pick_idx_s;
          op_d    = pick_op_s;
          fault_d = pick_fault_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle: grant and strobe enter ISSUE, done/rdata enter DONE.
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s && !pick_fault_s) begin
          gnt_d = pick_win_s;
          if (pick_op_s == OP_PUSH) begin
            wr_d  = 1'b1;
            din_d = pick_data_s;
          end else begin
            rd_d = 1'b1;
          end
        end else if (pick_any_s) begin
          gnt_d = pick_win_s;
        end else begin
          gnt_d = '0;
        end
      end
      WAIT: begin
        done_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        err_d  = fault_q;
        if (!fault_q && op_q == OP_POP) begin
          rdata_d = lifo_dout;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign lifo_write = wr_q;
  assign lifo_read  = rd_q;
  assign lifo_din   = din_q;

endmodule

// File: doc/lifo_req_arbiter.md
Name: lifo_req_arbiter

Overview:
- Shares one 4-deep, 6-bit LIFO between NUM_REQ independent requesters, e.g. a button/switch pusher and a display popper on the Nexys3 top level.
- Serialises push/pop requests with round-robin arbitration.
- Generates single-cycle write/read strobes to the LIFO and waits for its registered data_out and flags to settle.
- Returns a done pulse with pop data, or an error, to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DW, 6, data width; must match the LIFO data width.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held high until done for that requester.
- op  in  NUM_REQ  per-requester operation: 1 = push, 0 = pop; stable while req is high.
- wdata  in  NUM_REQ*DW  per-requester push data, slice k = requester k; stable while req is high.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err  out  1  valid with done: 1 = push while full or pop while empty; no LIFO access made.
- rdata  out  DW  pop result, valid with done for a successful pop; otherwise holds its last value.
- busy  out  1  high in any state other than IDLE.
- lifo_write  out  1  write strobe to the LIFO.
- lifo_read  out  1  read strobe to the LIFO.
- lifo_din  out  DW  push data to the LIFO.
- lifo_dout  in  DW  LIFO data_out.
- lifo_empty  in  1  LIFO empty flag.
- lifo_full  in  1  LIFO full flag.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE; rr pointer = 0.
  - gnt, done, err, busy, lifo_write, lifo_read = 0; rdata = 0; lifo_din = 0.
- All outputs are registered.
- Only one of lifo_write and lifo_read is ever high. Each is high for exactly one cycle, and never both.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req is high at edge T0: choose the winner k by round-robin, searching from the rr pointer upward and wrapping.
  - Latch idx = k, op_k and wdata_k.
  - Latch the error condition: op_k = 1 and lifo_full = 1, or op_k = 0 and lifo_empty = 1.
  - Go to ISSUE. Set rr pointer = (k+1) mod NUM_REQ.
  - No req high: remain in IDLE; outputs stay idle.
- ISSUE (cycle T0+1):
  - gnt[k] = 1.
  - If no error: lifo_write = 1 with lifo_din = latched wdata (push), or lifo_read = 1 (pop).
  - If error: no strobe.
- WAIT (cycle T0+2):
  - The LIFO has updated on the ISSUE->WAIT edge.
  - At the end of WAIT, capture lifo_dout into rdata for a successful pop only.
- DONE (cycle T0+3):
  - done[k] = 1; err = latched error flag.
  - Next state IDLE.
  - Requester k drops req at or after done. A req still sampled high in the IDLE cycle is treated as a new request.
- Latency: a request sampled at T0 gets gnt at T0+1 and done at T0+3. Throughput is one operation per 4 cycles.
- Error path: identical timing, no LIFO strobe, rdata unchanged, err = 1 with done.
- Arbitration:
  - Requests arriving outside IDLE wait; they are never dropped while req is held.
  - Simultaneous requests are resolved by the rr pointer only.
  - A requester that has just been served has lowest priority next time.
- Flags are sampled only in IDLE. The arbiter is the sole LIFO driver, so flags are stable there.
- Reset mid-operation returns to IDLE immediately and drops any pending strobe or done. LIFO contents are the LIFO's own concern.

Decomposition:
- Package lifo_pkg:
  - LIFO_DW = 6, LIFO_DEPTH = 4.
  - OP_PUSH = 1, OP_POP = 0.
  - State encoding IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, DONE = 2'b11.
- One sub-module, rr_pick: combinational round-robin selector with inputs req and rr pointer, outputs one-hot winner, index and any_req.

Test Plan:
- Single push, LIFO empty: req[0] = 1, op = 1, wdata0 = 6'h2A.
  - gnt[0] at T0+1, lifo_write one cycle with lifo_din = 6'h2A.
  - done[0] at T0+3, err = 0, and lifo_empty drops.
- Push 6'h05, 6'h11, 6'h3F from req0, then 3 pops from req1.
  - rdata sequence 6'h3F, 6'h11, 6'h05, each with done[1] and err = 0.
- Overflow: push 4 items, then a 5th push of 6'h07.
  - done with err = 1, no lifo_write pulse, LIFO top still the 4th value.
- Underflow: pop on empty after reset.
  - done with err = 1, no lifo_read, rdata = 6'h00.
- Fairness: req0 and req1 both held high with pushes.
  - Grants alternate 0, 1, 0, 1.
  - After the first grant to 0, the next goes to 1 despite req0 still high.
  - Never more than one gnt bit high.
- Reset asserted during WAIT of a pop.
  - All outputs 0 asynchronously, no done pulse afterwards.
  - After release, the next request completes normally in 4 cycles.
